// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the HI/LO divide sequencer slice.
//   DATA_W      : machine word width
//   DIV_LATENCY : cycles the iterative divider takes from start to result
//   hd_state_t  : sequencer states (IDLE, LAUNCH, WAIT, FIX)
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int DATA_W      = 32;
    localparam int DIV_LATENCY = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        FIX    = 2'd3
    } hd_state_t;

endpackage

// File: rtl/abs_neg32.sv
// -----------------------------------------------------------------------------
// abs_neg32
// Combinational conditional two's-complement unit.
//   i_in     : input word
//   i_negate : 1 = output the two's-complement negation of i_in, 0 = pass
//   o_out    : result, modulo 2^DATA_W (so -0x80000000 stays 0x80000000)
// -----------------------------------------------------------------------------
module abs_neg32
    import mips_pkg::*;
(
    input  logic [DATA_W-1:0] i_in,
    input  logic              i_negate,
    output logic [DATA_W-1:0] o_out
);

    assign o_out = i_negate ? (~i_in + DATA_W'(1)) : i_in;

endmodule

// File: rtl/hilo_div_ctrl.sv
// -----------------------------------------------------------------------------
// hilo_div_ctrl
// Sequencer between execute and an iterative unsigned 32-bit divider. Converts
// DIV operands to magnitudes, launches the divider, waits for its result (with
// a timeout), sign-fixes quotient/remainder and writes the architectural HI/LO
// registers. Also serves MTHI/MTLO writes while no divide is in flight.
//
// Parameters
//   TIMEOUT_CYCLES : WAIT cycles before abort (must exceed divider worst case)
//   CNT_W          : timeout counter width, 2**CNT_W > TIMEOUT_CYCLES
//
// Ports
//   clk, reset               : clock, asynchronous active-high reset
//   op_valid/op_signed       : divide request, 1 = DIV, 0 = DIVU
//   op_a/op_b                : dividend / divisor
//   op_ready                 : high only in IDLE; accept = op_valid & op_ready
//   mthi_we/mtlo_we/mt_data  : MTHI/MTLO write port (ignored while busy)
//   hi/lo                    : architectural remainder / quotient
//   busy                     : divide in flight (LAUNCH, WAIT, FIX)
//   div0/tmo                 : one-cycle divide-by-zero / timeout pulses
//   dv_start/dv_a/dv_b       : divider launch pulse and unsigned operands
//   dv_done/dv_q/dv_r        : divider result pulse and raw unsigned results
// -----------------------------------------------------------------------------
module hilo_div_ctrl
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 40,
    parameter int CNT_W          = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    input  logic              op_signed,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              op_ready,
    input  logic              mthi_we,
    input  logic              mtlo_we,
    input  logic [DATA_W-1:0] mt_data,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              div0,
    output logic              tmo,
    output logic              dv_start,
    output logic [DATA_W-1:0] dv_a,
    output logic [DATA_W-1:0] dv_b,
    input  logic              dv_done,
    input  logic [DATA_W-1:0] dv_q,
    input  logic [DATA_W-1:0] dv_r
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    hd_state_t         r_state;
    hd_state_t         w_state_next;

    logic [CNT_W-1:0]  r_cnt;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [DATA_W-1:0] r_dv_a;
    logic [DATA_W-1:0] r_dv_b;
    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] r_r;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic              r_div0;
    logic              r_tmo;

    logic              w_accept;
    logic              w_b_zero;
    logic              w_timeout;
    logic              w_load_ops;
    logic              w_set_div0;
    logic              w_set_tmo;
    logic              w_capture;
    logic              w_write_hilo;

    logic [DATA_W-1:0] w_op_in  [2];
    logic              w_op_neg [2];
    logic [DATA_W-1:0] w_mag    [2];
    logic [DATA_W-1:0] w_q_fix;
    logic [DATA_W-1:0] w_r_fix;

    // -------------------------------------------------------------------------
    // Upstream: operand magnitudes (index 0 = dividend, 1 = divisor). Only
    // signed requests with a negative operand are negated.
    // -------------------------------------------------------------------------
    assign w_op_in[0]  = op_a;
    assign w_op_in[1]  = op_b;
    assign w_op_neg[0] = op_signed & op_a[DATA_W-1];
    assign w_op_neg[1] = op_signed & op_b[DATA_W-1];

    for (genvar gi = 0; gi < 2; gi++) begin : g_mag
        abs_neg32 u_mag (
            .i_in     (w_op_in[gi]),
            .i_negate (w_op_neg[gi]),
            .o_out    (w_mag[gi])
        );
    end

    // -------------------------------------------------------------------------
    // Downstream: sign fix of the raw divider results. Quotient is negative
    // when operand signs differ; remainder takes the dividend's sign.
    // -------------------------------------------------------------------------
    abs_neg32 u_fix_q (
        .i_in     (r_q),
        .i_negate (r_neg_q),
        .o_out    (w_q_fix)
    );

    abs_neg32 u_fix_r (
        .i_in     (r_r),
        .i_negate (r_neg_r),
        .o_out    (w_r_fix)
    );

    // -------------------------------------------------------------------------
    // Control
    // -------------------------------------------------------------------------
    assign op_ready  = (r_state == IDLE);
    assign busy      = ~op_ready;
    assign dv_start  = (r_state == LAUNCH);
    assign w_accept  = op_valid & op_ready;
    assign w_b_zero  = (op_b == '0);
    assign w_timeout = (r_cnt == TMO_LAST);

    // NOTE: sequential state is updated with <= so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_load_ops   = 1'b0;
        w_set_div0   = 1'b0;
        w_set_tmo    = 1'b0;
        w_capture    = 1'b0;
        w_write_hilo = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_b_zero) begin
                        // Divide-by-zero never reaches the divider.
                        w_set_div0 = 1'b1;
                    end else begin
                        w_load_ops   = 1'b1;
                        w_state_next = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                w_state_next = WAIT;
            end
            WAIT: begin
                // A result arriving on the last allowed cycle still wins.
                if (dv_done) begin
                    w_capture    = 1'b1;
                    w_state_next = FIX;
                end else if (w_timeout) begin
                    w_set_tmo    = 1'b1;
                    w_state_next = IDLE;
                end
            end
            FIX: begin
                w_write_hilo = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // NOTE: HI/LO and the operand/result holding registers are reset too:
    // HI/LO are architectural and must read 0 after reset, and dv_a/dv_b are
    // visible outputs.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dv_a  <= '0;
            r_dv_b  <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_div0  <= 1'b0;
            r_tmo   <= 1'b0;
        end else begin
            r_div0 <= w_set_div0;
            r_tmo  <= w_set_tmo;

            if (w_load_ops) begin
                r_neg_q <= op_signed & (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
                r_neg_r <= op_signed & op_a[DATA_W-1];
                r_dv_a  <= w_mag[0];
                r_dv_b  <= w_mag[1];
            end

            // Counter value k means k+1 WAIT cycles have elapsed.
            if (r_state == LAUNCH) begin
                r_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_capture) begin
                r_q <= dv_q;
                r_r <= dv_r;
            end

            // FIX only happens while busy, MT writes only while idle, so the
            // two sources never compete for HI/LO.
            if (w_write_hilo) begin
                r_hi <= w_r_fix;
                r_lo <= w_q_fix;
            end else if (op_ready) begin
                if (mthi_we) begin
                    r_hi <= mt_data;
                end
                if (mtlo_we) begin
                    r_lo <= mt_data;
                end
            end
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign div0 = r_div0;
    assign tmo  = r_tmo;
    assign dv_a = r_dv_a;
    assign dv_b = r_dv_b;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hilo_div_ctrl
// Self-checking bench for hilo_div_ctrl. A behavioural divider stub answers
// DIV_LATENCY cycles after each start (or never, in hang mode). Expected
// HI/LO/operand values come from plain 64-bit signed arithmetic.
// -----------------------------------------------------------------------------
module tb_hilo_div_ctrl;
    import mips_pkg::*;

    localparam int TMO_CYCLES = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid, op_signed;
    logic [31:0] op_a, op_b;
    logic        op_ready;
    logic        mthi_we, mtlo_we;
    logic [31:0] mt_data;
    logic [31:0] hi, lo;
    logic        busy, div0, tmo, dv_start;
    logic [31:0] dv_a, dv_b;
    logic        dv_done;
    logic [31:0] dv_q, dv_r;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hilo_div_ctrl #(.TIMEOUT_CYCLES(TMO_CYCLES), .CNT_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .op_valid  (op_valid),
        .op_signed (op_signed),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_ready  (op_ready),
        .mthi_we   (mthi_we),
        .mtlo_we   (mtlo_we),
        .mt_data   (mt_data),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .div0      (div0),
        .tmo       (tmo),
        .dv_start  (dv_start),
        .dv_a      (dv_a),
        .dv_b      (dv_b),
        .dv_done   (dv_done),
        .dv_q      (dv_q),
        .dv_r      (dv_r)
    );

    // ---------------- divider stub ----------------
    logic        hang;
    logic        inject_done;
    logic [31:0] inj_q, inj_r;
    logic        stub_done, stub_busy;
    logic [31:0] stub_q, stub_r;
    int          stub_cnt;

    assign dv_done = stub_done | inject_done;
    assign dv_q    = inject_done ? inj_q : stub_q;
    assign dv_r    = inject_done ? inj_r : stub_r;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            stub_done <= 1'b0;
            stub_busy <= 1'b0;
            stub_cnt  <= 0;
            stub_q    <= '0;
            stub_r    <= '0;
        end else begin
            stub_done <= 1'b0;
            if (dv_start) begin
                stub_busy <= 1'b1;
                stub_cnt  <= 0;
                stub_q    <= (dv_b != 0) ? dv_a / dv_b : '1;
                stub_r    <= (dv_b != 0) ? dv_a % dv_b : dv_a;
            end else if (stub_busy) begin
                if (stub_cnt == DIV_LATENCY - 1) begin
                    stub_busy <= 1'b0;
                    stub_done <= ~hang;
                end else begin
                    stub_cnt <= stub_cnt + 1;
                end
            end
        end
    end

    // ---------------- protocol monitor ----------------
    always @(posedge clk) begin
        if (!reset) begin
            if (div0 && tmo) begin
                n_fail++;
                $display("FAIL mon_div0_tmo: both high at %0t", $time);
            end
            if (busy && (mthi_we || mtlo_we)) begin
                n_fail++;
                $display("FAIL mon_mt_busy: mt write while busy at %0t", $time);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic void model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic [31:0] ma, output logic [31:0] mb);
        longint sa, sb, lq, lr;
        if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = {32'b0, a};
            sb = {32'b0, b};
        end
        lq = sa / sb;
        lr = sa % sb;
        q  = 32'(lq);
        r  = 32'(lr);
        ma = 32'((sa < 0) ? -sa : sa);
        mb = 32'((sb < 0) ? -sb : sb);
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Full divide: request, launch checks, latency, single start, result.
    task automatic do_div(input string nm, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eq, er, ema, emb;
        int lat, starts, flags;
        logic stable;
        model(sgn, a, b, eq, er, ema, emb);
        n_tests++;
        if (op_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready: got %b want 1", nm, op_ready);
        end
        op_valid = 1'b1; op_signed = sgn; op_a = a; op_b = b;
        tick();
        op_valid = 1'b0; op_a = $urandom; op_b = $urandom;
        n_tests++;
        if ({busy, dv_start, dv_a, dv_b} !== {1'b1, 1'b1, ema, emb}) begin
            n_fail++;
            $display("FAIL %s launch: busy=%b start=%b a=%h b=%h want 1 1 %h %h",
                     nm, busy, dv_start, dv_a, dv_b, ema, emb);
        end
        lat = 0; starts = 1; flags = 0; stable = 1'b1;
        while (busy && lat < 100) begin
            tick();
            lat++;
            if (dv_start) starts++;
            if (div0 || tmo) flags++;
            if (busy && (dv_a !== ema || dv_b !== emb)) stable = 1'b0;
        end
        n_tests++;
        if (lat != 3 + DIV_LATENCY) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want %0d", nm, lat, 3 + DIV_LATENCY);
        end
        n_tests++;
        if (starts != 1 || flags != 0 || !stable) begin
            n_fail++;
            $display("FAIL %s ctrl: starts=%0d flags=%0d stable=%b want 1 0 1", nm, starts, flags, stable);
        end
        n_tests++;
        if (lo !== eq || hi !== er) begin
            n_fail++;
            $display("FAIL %s result: lo=%h hi=%h want lo=%h hi=%h", nm, lo, hi, eq, er);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        op_valid = 0; op_signed = 0; op_a = 0; op_b = 0;
        mthi_we = 0; mtlo_we = 0; mt_data = 0;
        hang = 0; inject_done = 0; inj_q = 0; inj_r = 0;
        tick(); tick();
        reset = 1'b0;
        tick();
        n_tests++;
        if ({hi, lo} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_hilo: hi=%h lo=%h want 0 0", hi, lo);
        end
        n_tests++;
        if ({busy, div0, tmo, dv_start, op_ready, dv_a, dv_b} !== {5'b00001, 64'h0}) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy=%b div0=%b tmo=%b start=%b ready=%b a=%h b=%h want 0 0 0 0 1 0 0",
                     busy, div0, tmo, dv_start, op_ready, dv_a, dv_b);
        end
    endtask

    task automatic test_divu_basic();
        do_div("divu_100_7", 1'b0, 32'd100, 32'd7);
        n_tests++;
        if (lo !== 32'd14 || hi !== 32'd2) begin
            n_fail++;
            $display("FAIL divu_100_7_const: lo=%h hi=%h want e 2", lo, hi);
        end
    endtask

    task automatic test_signed();
        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        n_tests++;
        if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL div_m7_2_const: lo=%h hi=%h want fffffffd ffffffff", lo, hi);
        end
    endtask

    task automatic test_corners();
        do_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        n_tests++;
        if (lo !== 32'h8000_0000 || hi !== 32'h0) begin
            n_fail++;
            $display("FAIL div_min_m1_const: lo=%h hi=%h want 80000000 0", lo, hi);
        end
        do_div("divu_max_2", 1'b0, 32'hFFFF_FFFF, 32'd2);
        n_tests++;
        if (lo !== 32'h7FFF_FFFF || hi !== 32'h1) begin
            n_fail++;
            $display("FAIL divu_max_2_const: lo=%h hi=%h want 7fffffff 1", lo, hi);
        end
    endtask

    task automatic test_div0();
        int starts;
        mthi_we = 1'b1; mt_data = 32'h1234;
        tick();
        mthi_we = 1'b0; mtlo_we = 1'b1; mt_data = 32'h5678;
        tick();
        mtlo_we = 1'b0;
        n_tests++;
        if (hi !== 32'h1234 || lo !== 32'h5678) begin
            n_fail++;
            $display("FAIL mt_preload: hi=%h lo=%h want 1234 5678", hi, lo);
        end
        op_valid = 1'b1; op_signed = 1'b1; op_a = 32'd5; op_b = 32'd0;
        tick();
        op_valid = 1'b0;
        starts = dv_start ? 1 : 0;
        n_tests++;
        if ({div0, busy, op_ready} !== 3'b101) begin
            n_fail++;
            $display("FAIL div0_pulse: div0=%b busy=%b ready=%b want 1 0 1", div0, busy, op_ready);
        end
        tick();
        if (dv_start) starts++;
        n_tests++;
        if (div0 !== 1'b0 || starts != 0 || op_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL div0_after: div0=%b starts=%0d ready=%b want 0 0 1", div0, starts, op_ready);
        end
        n_tests++;
        if (hi !== 32'h1234 || lo !== 32'h5678) begin
            n_fail++;
            $display("FAIL div0_hilo: hi=%h lo=%h want 1234 5678", hi, lo);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] hi0, lo0;
        int lat, tmos;
        hi0 = hi; lo0 = lo;
        hang = 1'b1;
        op_valid = 1'b1; op_signed = 1'b0; op_a = 32'd1000; op_b = 32'd3;
        tick();
        op_valid = 1'b0;
        lat = 0; tmos = 0;
        while (busy && lat < 100) begin
            tick();
            lat++;
            if (tmo) tmos++;
        end
        n_tests++;
        if (lat != TMO_CYCLES + 1 || tmos != 1 || tmo !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_pulse: busy_fall=%0d tmo_cycles=%0d tmo=%b want %0d 1 1",
                     lat, tmos, tmo, TMO_CYCLES + 1);
        end
        tick();
        n_tests++;
        if (tmo !== 1'b0 || hi !== hi0 || lo !== lo0) begin
            n_fail++;
            $display("FAIL tmo_after: tmo=%b hi=%h lo=%h want 0 %h %h", tmo, hi, lo, hi0, lo0);
        end
        hang = 1'b0;
        do_div("after_tmo", 1'b1, 32'd1000, 32'hFFFF_FFFD);
    endtask

    task automatic test_back_to_back();
        logic [31:0] eq, er, ema, emb;
        int lat;
        model(1'b1, 32'hFFFF_FF9C, 32'd7, eq, er, ema, emb);
        mtlo_we = 1'b1; mt_data = 32'hCAFE_0001;
        op_valid = 1'b1; op_signed = 1'b1; op_a = 32'hFFFF_FF9C; op_b = 32'd7;
        tick();
        mtlo_we = 1'b0; op_valid = 1'b0;
        n_tests++;
        if (lo !== 32'hCAFE_0001 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mt_with_op: lo=%h busy=%b want cafe0001 1", lo, busy);
        end
        lat = 0;
        while (busy && lat < 100) begin
            tick();
            lat++;
        end
        n_tests++;
        if (lo !== eq || hi !== er || lo !== 32'hFFFF_FFF2 || hi !== 32'hFFFF_FFFE) begin
            n_fail++;
            $display("FAIL mt_then_div: lo=%h hi=%h want fffffff2 fffffffe", lo, hi);
        end
        // Next request issued on the very first idle cycle.
        do_div("b2b", 1'b0, 32'd12345678, 32'd1000);
    endtask

    task automatic test_random();
        logic        sgn;
        logic [31:0] a, b;
        for (int i = 0; i < 20; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = $urandom_range(1, 20);
                2: begin a = $urandom_range(0, 50); b = $urandom; end
                default: begin a = 32'h8000_0000; b = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'd1; end
            endcase
            if (b == 32'd0) b = 32'd1;
            do_div($sformatf("rand%0d", i), sgn, a, b);
        end
    endtask

    task automatic test_reset_mid();
        op_valid = 1'b1; op_signed = 1'b0; op_a = $urandom; op_b = $urandom_range(1, 1000);
        tick();
        op_valid = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        #1;
        n_tests++;
        if ({hi, lo, dv_a, dv_b} !== 128'h0 || {busy, div0, tmo, dv_start, op_ready} !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_mid: hi=%h lo=%h a=%h b=%h busy=%b start=%b ready=%b want all 0 ready 1",
                     hi, lo, dv_a, dv_b, busy, dv_start, op_ready);
        end
        tick();
        reset = 1'b0;
        tick();
        inject_done = 1'b1; inj_q = 32'hDEAD_BEEF; inj_r = 32'h0BAD_F00D;
        tick();
        inject_done = 1'b0;
        tick(); tick();
        n_tests++;
        if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL late_done: hi=%h lo=%h busy=%b want 0 0 0", hi, lo, busy);
        end
        mthi_we = 1'b1; mt_data = 32'hA5A5_A5A5;
        tick();
        mthi_we = 1'b0;
        n_tests++;
        if (hi !== 32'hA5A5_A5A5 || lo !== 32'h0) begin
            n_fail++;
            $display("FAIL mthi_after_reset: hi=%h lo=%h want a5a5a5a5 0", hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_signed();
        test_corners();
        test_div0();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
